ultrasonic_trigger: RTL and testbench
=====================================

Name: ultrasonic_trigger

Overview:
Generates the periodic trigger pulse for an HC-SR04-style ultrasonic ranger and measures the width of the returned echo pulse in clock cycles. It sits between the board pins (trigger out, echo in) and the distance-calculation logic, which consumes the echo width and valid/timeout strobes. The nominal clock is 50 MHz (20 ns period).

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
PERIOD_CYCLES, 3000000, trigger rising edge to next trigger rising edge (60 ms)
TIMEOUT_CYCLES, 1900000, max wait for echo rise and max echo width (38 ms)
CNT_W, 22, width of all internal counters and echo_cycles; must hold PERIOD_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
echo  input  1  asynchronous echo pin from sensor
trigger  output  1  trigger pin to sensor, registered
echo_cycles  output  CNT_W  last valid echo width in clk cycles
meas_valid  output  1  one-cycle strobe: echo_cycles just updated
timeout  output  1  one-cycle strobe: measurement abandoned
busy  output  1  high whenever state is not HOLDOFF

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: trigger=0, echo_cycles=0, meas_valid=0, timeout=0, busy=0. State is TRIG_START; all counters are 0.
- Echo input: two-flop synchronizer (echo_s). Rise and fall are detected on echo_s against its previous value, which adds 2-3 cycles of latency. Both synchronizer flops reset to 0.
- Period counter: clears on the cycle trigger rises. Otherwise increments every cycle and saturates at PERIOD_CYCLES-1.
- States:
  - TRIG_START: the first cycle after reset release. Sets trigger=1 and clears the period and trigger counters. Goes to TRIG.
  - TRIG: trigger stays 1 for exactly TRIG_CYCLES cycles in total. Then trigger=0 and the state goes to WAIT_RISE with the wait counter cleared.
  - WAIT_RISE: increments the wait counter each cycle.
    - On an echo_s rising edge: go to MEASURE with the width counter set to 1.
    - If the wait counter reaches TIMEOUT_CYCLES: pulse timeout for 1 cycle and go to HOLDOFF.
    - An echo already high on entry is not a rising edge and is ignored.
  - MEASURE: increments the width counter while echo_s=1.
    - On an echo_s falling edge: echo_cycles <= width count, meas_valid pulses 1 cycle, go to HOLDOFF.
    - If the width reaches TIMEOUT_CYCLES: pulse timeout, leave echo_cycles unchanged, go to HOLDOFF.
  - HOLDOFF: busy=0. When the period counter equals PERIOD_CYCLES-1 AND echo_s=0, the next cycle raises trigger (same actions as TRIG_START).
    - If echo_s is still high at that point, wait until it is low. The period is then stretched, never shortened.
- meas_valid and timeout are never asserted in the same cycle.
- rst mid-operation: trigger drops to 0 on the next edge. Any pending measurement is discarded with no strobe. The cycle restarts from TRIG_START.
- Echo activity during TRIG or HOLDOFF is ignored (no strobes).

Decomposition:
- Shared package ultrasonic_pkg: state enum (TRIG_START, TRIG, WAIT_RISE, MEASURE, HOLDOFF) and default timing constants for 50 MHz.
- One natural sub-module: sync_edge. It holds the two-flop synchronizer plus the rise/fall pulse outputs, with the same clk/rst.

Test Plan:
Benches use TRIG_CYCLES=5, PERIOD_CYCLES=100, TIMEOUT_CYCLES=40.
1. Reset, then release with echo=0 -> trigger high exactly 5 cycles starting 1 cycle after release. No echo, so timeout pulses once, 40 cycles after trigger falls. The next trigger rise is exactly 100 cycles after the first. busy is low in HOLDOFF.
2. Echo raised 10 cycles after trigger falls and held for 20 cycles -> meas_valid pulses once, echo_cycles=20, timeout stays 0.
3. Echo held high for 60 cycles -> timeout pulse when the width reaches 40. echo_cycles keeps its previous value (20 from scenario 2). The next trigger is delayed until echo_s=0.
4. Echo high before and during trigger, then falling, then a 15-cycle pulse -> the first level is ignored, echo_cycles=15.
5. Assert rst mid-MEASURE for 1 cycle -> trigger=0 and echo_cycles=0 after the edge, no strobe. A new 5-cycle trigger begins 1 cycle after release.
6. Echo width of 1 cycle (minimum) -> echo_cycles=1, meas_valid pulse. Echo width of 39 -> echo_cycles=39, no timeout.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg
// Shared definitions for the HC-SR04-style ultrasonic trigger/echo block:
// the controller state encoding and default timing constants for a 50 MHz
// clock (20 ns period).
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    TRIG_START = 3'd0,  // first cycle of a new period: raise trigger
    TRIG       = 3'd1,  // trigger held high
    WAIT_RISE  = 3'd2,  // listening for the echo to start
    MEASURE    = 3'd3,  // echo high, counting its width
    HOLDOFF    = 3'd4   // idle until the period elapses and echo is low
  } state_t;

  // 10 us trigger pulse at 50 MHz
  localparam int unsigned DEF_TRIG_CYCLES    = 32'd500;
  // 60 ms from one trigger rising edge to the next
  localparam int unsigned DEF_PERIOD_CYCLES  = 32'd3000000;
  // 38 ms: longest wait for echo rise and longest accepted echo
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1900000;
  // counter width, large enough to hold DEF_PERIOD_CYCLES
  localparam int unsigned DEF_CNT_W          = 32'd22;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous input plus single-cycle
// rise/fall pulses derived from the synchronized level and its previous
// value.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active high (clears all flops to 0)
//   din  - asynchronous input pin
//   dout - synchronized level
//   rise - one-cycle pulse: dout went 0 -> 1
//   fall - one-cycle pulse: dout went 1 -> 0
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign dout = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/ultrasonic_trigger.sv
// ultrasonic_trigger
// Emits the periodic trigger pulse for an HC-SR04-style ranger and measures
// the returned echo width in clock cycles.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous reset, active high
//   echo        - asynchronous echo pin from the sensor
//   trigger     - trigger pin to the sensor (registered)
//   echo_cycles - last valid echo width in clk cycles
//   meas_valid  - one-cycle strobe: echo_cycles just updated
//   timeout     - one-cycle strobe: measurement abandoned
//   busy        - high whenever the controller is not in HOLDOFF
module ultrasonic_trigger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             echo,
  output logic             trigger,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  // Counters are compared against "last" values before incrementing, so a
  // counter that has just been compared equal is about to reach the limit.
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic echo_s;
  logic echo_rise_s;
  logic echo_fall_s;

  state_t           state_r;
  logic             trigger_r;
  logic [CNT_W-1:0] period_cnt_r;
  logic [CNT_W-1:0] trig_cnt_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] width_cnt_r;
  logic [CNT_W-1:0] echo_cycles_r;
  logic             meas_valid_r;
  logic             timeout_r;
  logic             busy_r;

  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (echo),
    .dout (echo_s),
    .rise (echo_rise_s),
    .fall (echo_fall_s)
  );

  // Controller: trigger generation, echo timing and period pacing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= TRIG_START;
      trigger_r     <= 1'b0;
      period_cnt_r  <= '0;
      trig_cnt_r    <= '0;
      wait_cnt_r    <= '0;
      width_cnt_r   <= '0;
      echo_cycles_r <= '0;
      meas_valid_r  <= 1'b0;
      timeout_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      meas_valid_r <= 1'b0;
      timeout_r    <= 1'b0;

      // Free-running period counter; the trigger-rise branches below
      // override this with a clear.
      if (period_cnt_r != PERIOD_LAST) begin
        period_cnt_r <= period_cnt_r + CNT_ONE;
      end else begin
        period_cnt_r <= period_cnt_r;
      end

      case (state_r)
        TRIG_START: begin
          trigger_r    <= 1'b1;
          period_cnt_r <= '0;
          trig_cnt_r   <= '0;
          busy_r       <= 1'b1;
          state_r      <= TRIG;
        end

        TRIG: begin
          // trig_cnt_r counts cycles already spent high, starting at 0
          if (trig_cnt_r == TRIG_LAST) begin
            trigger_r  <= 1'b0;
            wait_cnt_r <= '0;
            state_r    <= WAIT_RISE;
          end else begin
            trig_cnt_r <= trig_cnt_r + CNT_ONE;
          end
        end

        WAIT_RISE: begin
          // Only a true 0->1 edge starts a measurement; a level that was
          // already high on entry never produces one.
          if (echo_rise_s) begin
            width_cnt_r <= CNT_ONE;
            state_r     <= MEASURE;
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= HOLDOFF;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end

        MEASURE: begin
          if (echo_fall_s) begin
            echo_cycles_r <= width_cnt_r;
            meas_valid_r  <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= HOLDOFF;
          end else if (width_cnt_r == TIMEOUT_LAST) begin
            // Echo would reach the limit this cycle: abandon, keep old width
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= HOLDOFF;
          end else if (echo_s) begin
            width_cnt_r <= width_cnt_r + CNT_ONE;
          end else begin
            width_cnt_r <= width_cnt_r;
          end
        end

        HOLDOFF: begin
          // A still-high echo stretches the period rather than letting the
          // next ping overlap the tail of the previous one.
          if ((period_cnt_r == PERIOD_LAST) && !echo_s) begin
            trigger_r    <= 1'b1;
            period_cnt_r <= '0;
            trig_cnt_r   <= '0;
            busy_r       <= 1'b1;
            state_r      <= TRIG;
          end else begin
            state_r <= HOLDOFF;
          end
        end

        default: begin
          trigger_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= TRIG_START;
        end
      endcase
    end
  end

  assign trigger     = trigger_r;
  assign echo_cycles = echo_cycles_r;
  assign meas_valid  = meas_valid_r;
  assign timeout     = timeout_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// tb_ultrasonic_trigger
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a timestamp-based
// behavioural model of the ranger's timing rules.
module tb_ultrasonic_trigger;

  localparam int TRIG_C    = 5;
  localparam int PERIOD_C  = 100;
  localparam int TIMEOUT_C = 40;
  localparam int CW        = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          echo = 1'b0;
  logic          trigger;
  logic [CW-1:0] echo_cycles;
  logic          meas_valid;
  logic          timeout;
  logic          busy;

  int errors = 0;
  int checks = 0;

  ultrasonic_trigger #(
    .TRIG_CYCLES    (TRIG_C),
    .PERIOD_CYCLES  (PERIOD_C),
    .TIMEOUT_CYCLES (TIMEOUT_C),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .echo        (echo),
    .trigger     (trigger),
    .echo_cycles (echo_cycles),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeline expressed as edge timestamps: n is the index of the current
  // clock edge, t_trig the edge at which trigger last rose, t_rise the edge
  // at which the echo start was accepted.
  int  n = 0;
  int  t_trig = 0;
  int  t_rise = 0;
  bit  started = 1'b0;
  bit  rose = 1'b0;
  bit  done = 1'b0;
  bit  checking = 1'b0;
  bit  d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;  // pin delayed 1, 2, 3 edges
  bit  exp_trigger = 1'b0, exp_valid = 1'b0, exp_timeout = 1'b0, exp_busy = 1'b0;
  int  exp_cycles = 0;

  initial forever begin
    bit es, ep, r_p, f_p;
    @(posedge clk);
    n++;
    if (rst) begin
      checking = 1'b1;
      started = 1'b0; rose = 1'b0; done = 1'b0;
      d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
      exp_trigger = 1'b0; exp_valid = 1'b0; exp_timeout = 1'b0;
      exp_busy = 1'b0; exp_cycles = 0;
    end else begin
      es = d2;               // synchronized echo seen at this edge
      ep = d3;               // its previous value
      r_p = es & ~ep;
      f_p = ~es & ep;
      exp_valid = 1'b0;
      exp_timeout = 1'b0;
      if (!started || (done && (n >= t_trig + PERIOD_C) && !es)) begin
        t_trig = n; started = 1'b1; rose = 1'b0; done = 1'b0;
      end else if (!done && (n > t_trig + TRIG_C)) begin
        if (!rose) begin
          if (r_p) begin
            rose = 1'b1; t_rise = n;
          end else if (n == t_trig + TRIG_C + TIMEOUT_C) begin
            done = 1'b1; exp_timeout = 1'b1;
          end
        end else begin
          if (f_p) begin
            exp_cycles = n - t_rise; exp_valid = 1'b1; done = 1'b1;
          end else if (n - t_rise == TIMEOUT_C - 1) begin
            exp_timeout = 1'b1; done = 1'b1;
          end
        end
      end
      exp_trigger = (n - t_trig) < TRIG_C;
      exp_busy = !done;
      d3 = d2; d2 = d1; d1 = echo;
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("trigger", {31'd0, trigger}, {31'd0, exp_trigger});
      check("meas_valid", {31'd0, meas_valid}, {31'd0, exp_valid});
      check("timeout", {31'd0, timeout}, {31'd0, exp_timeout});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("echo_cycles", 32'(echo_cycles), 32'(exp_cycles));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_edge(input logic lvl, input string nm);
    int i = 0;
    while (trigger === lvl && i < 400) begin @(negedge clk); i++; end
    while (trigger !== lvl && i < 400) begin @(negedge clk); i++; end
    if (i >= 400) begin
      checks++; errors++;
      $display("FAIL %s: trigger never reached %0d within 400 cycles", nm, lvl);
    end
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    while (trigger === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
  endtask

  task automatic wait_valid(input string nm);
    int i = 0;
    while (meas_valid !== 1'b1 && i < 20) begin @(negedge clk); i++; end
    if (i >= 20) begin
      checks++; errors++;
      $display("FAIL %s: meas_valid never pulsed within 20 cycles", nm);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  hi, k, d, w, g;
    time t1;
    rst = 1'b1; echo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_trigger", {31'd0, trigger}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // S1: no echo -> trigger pulse, timeout, exact period
    @(negedge clk);
    check("s1_trig_after_release", {31'd0, trigger}, 32'd1);
    check("s1_busy_high", {31'd0, busy}, 32'd1);
    t1 = $time;
    count_high(hi);
    check("s1_trig_width", hi, 32'd5);
    k = 0;
    while (timeout !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("s1_timeout_delay", k, 32'd40);
    check("s1_model_timeout", {31'd0, exp_timeout}, 32'd1);
    check("s1_busy_holdoff", {31'd0, busy}, 32'd0);
    wait_edge(1'b1, "s1_next_rise");
    check("s1_period", 32'(($time - t1) / 20), 32'd100);

    // S2: 20-cycle echo starting 10 cycles after trigger falls
    wait_edge(1'b0, "s2_fall");
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (20) @(negedge clk);
    echo = 1'b0;
    wait_valid("s2_valid");
    check("s2_echo_cycles", 32'(echo_cycles), 32'd20);
    check("s2_model_cycles", exp_cycles, 32'd20);

    // S3: 60-cycle echo times out at width 40, old width kept
    wait_edge(1'b1, "s3_rise");
    wait_edge(1'b0, "s3_fall");
    repeat (10) @(negedge clk);
    echo = 1'b1;
    k = 0;
    while (timeout !== 1'b1 && k < 80) begin @(negedge clk); k++; end
    check("s3_timeout_delay", k, 32'd42);
    check("s3_echo_kept", 32'(echo_cycles), 32'd20);
    repeat (60 - k) @(negedge clk);
    echo = 1'b0;

    // S3b: echo still high at period end stretches the period
    wait_edge(1'b1, "s3b_rise");
    t1 = $time;
    wait_edge(1'b0, "s3b_fall");
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (120) @(negedge clk);
    echo = 1'b0;
    wait_edge(1'b1, "s3b_next_rise");
    check("s3b_stretched_period", 32'(($time - t1) / 20), 32'd138);

    // S4: echo high during trigger is ignored, then a 15-cycle pulse
    echo = 1'b1;
    wait_edge(1'b0, "s4_fall");
    repeat (5) @(negedge clk);
    echo = 1'b0;
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (15) @(negedge clk);
    echo = 1'b0;
    wait_valid("s4_valid");
    check("s4_echo_cycles", 32'(echo_cycles), 32'd15);

    // S5: reset in the middle of a measurement
    wait_edge(1'b1, "s5_rise");
    wait_edge(1'b0, "s5_fall");
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1; echo = 1'b0;
    @(negedge clk);
    check("s5_trigger_low", {31'd0, trigger}, 32'd0);
    check("s5_echo_cleared", 32'(echo_cycles), 32'd0);
    check("s5_no_valid", {31'd0, meas_valid}, 32'd0);
    check("s5_no_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("s5_trig_restart", {31'd0, trigger}, 32'd1);
    count_high(hi);
    check("s5_trig_width", hi, 32'd5);

    // S6: minimum and near-limit widths
    repeat (8) @(negedge clk);
    echo = 1'b1;
    @(negedge clk);
    echo = 1'b0;
    wait_valid("s6_valid_1");
    check("s6_echo_1", 32'(echo_cycles), 32'd1);
    wait_edge(1'b1, "s6_rise");
    wait_edge(1'b0, "s6_fall");
    repeat (8) @(negedge clk);
    echo = 1'b1;
    repeat (39) @(negedge clk);
    echo = 1'b0;
    wait_valid("s6_valid_39");
    check("s6_echo_39", 32'(echo_cycles), 32'd39);

    // Randomized periods: random delay/width, holdoff noise, rare resets
    for (int p = 0; p < 15; p++) begin
      wait_edge(1'b1, "rnd_rise");
      wait_edge(1'b0, "rnd_fall");
      d = $urandom_range(0, 50);
      w = $urandom_range(1, 60);
      repeat (d) @(negedge clk);
      echo = 1'b1;
      for (int j = 0; j < w; j++) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
      end
      echo = 1'b0;
      g = $urandom_range(0, 4);
      for (int j = 0; j < g; j++) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        echo = ~echo;
      end
      echo = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
